// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the datapath requesters and the register-file write arbiter.
// master = requester side, slave = arbiter side.
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16
);
   logic [NUM_REQ-1:0]        Req;
   logic [4*NUM_REQ-1:0]      ReqAdd;
   logic [DATA_W*NUM_REQ-1:0] ReqData;
   logic [NUM_REQ-1:0]        Grant;
   logic [3:0]                RegAdd;
   logic                      WE;
   logic [DATA_W-1:0]         WrData;
   logic                      InitDone;

   modport master (
      output Req, ReqAdd, ReqData,
      input  Grant, RegAdd, WE, WrData, InitDone
   );

   modport slave (
      input  Req, ReqAdd, ReqData,
      output Grant, RegAdd, WE, WrData, InitDone
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the register bank; after reset it sweeps
// zeros into all 16 registers before any requester is granted.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   regfile_write_arbiter_if.slave   bus
);

   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic {INIT, ARB} state_t;

   state_t                 r_state;
   logic [3:0]             r_cnt;
   logic [PTR_W-1:0]       r_ptr;
   logic [3:0]             r_reg_add;
   logic                   r_we;
   logic [DATA_W-1:0]      r_wr_data;
   logic                   r_init_done;

   logic                   w_found;
   logic [PTR_W-1:0]       w_winner;
   logic [PTR_W:0]         w_sum;
   logic [PTR_W-1:0]       w_ptr_nxt;
   logic [3:0]             w_add_arr  [NUM_REQ];
   logic [DATA_W-1:0]      w_data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_add_arr[i]  = bus.ReqAdd[4*i +: 4];
      assign w_data_arr[i] = bus.ReqData[DATA_W*i +: DATA_W];
   end

   // Search upward from r_ptr, wrapping at NUM_REQ-1, for the first pending request.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
         if (w_sum >= (PTR_W+1)'(NUM_REQ)) w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
         if (!w_found && bus.Req[w_sum[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[PTR_W-1:0];
         end
      end
   end

   assign w_ptr_nxt = (w_winner == PTR_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;

   assign bus.Grant    = (r_state == ARB && w_found) ? (NUM_REQ'(1) << w_winner) : '0;
   assign bus.RegAdd   = r_reg_add;
   assign bus.WE       = r_we;
   assign bus.WrData   = r_wr_data;
   assign bus.InitDone = r_init_done;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state     <= INIT;
         r_cnt       <= '0;
         r_ptr       <= '0;
         r_reg_add   <= '0;
         r_we        <= 1'b0;
         r_wr_data   <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               r_reg_add <= r_cnt;
               r_we      <= 1'b1;
               r_wr_data <= '0;
               r_cnt     <= r_cnt + 4'd1;
               if (r_cnt == 4'hF) begin
                  r_state     <= ARB;
                  r_init_done <= 1'b1;
               end
            end
            ARB: begin
               // Idle cycles hold address and data; only the enable drops.
               if (w_found) begin
                  r_reg_add <= w_add_arr[w_winner];
                  r_wr_data <= w_data_arr[w_winner];
                  r_we      <= 1'b1;
                  r_ptr     <= w_ptr_nxt;
               end else begin
                  r_we <= 1'b0;
               end
            end
            default: r_state <= INIT;
         endcase
      end
   end

endmodule
